// File: rtl/wta_spi_pkg.sv
// Shared definitions for the WTA SPI host and the responder-side bench.
package wta_spi_pkg;

    localparam int SPI1_FRAME_W = 96;
    localparam int SPI2_FRAME_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_host_state_t;

    // Slave select is driven low only while the frame is on the wire.
    function automatic logic ss_active(spi_host_state_t st);
        return (st == SETUP) || (st == SHIFT);
    endfunction

endpackage

// File: rtl/wta_spi_bit_timer.sv
// Bit-period divider: counts CLK_DIV clk cycles and flags the last one.
module wta_spi_bit_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/wta_spi_host.sv
// Full-duplex SPI frame initiator for one WTA responder port (MSB first).
// Optional WTA_SPI_HOST_LOOPBACK_EN adds i_loopback (capture from own mosi).
module wta_spi_host
    import wta_spi_pkg::*;
#(
    parameter int FRAME_W = 96,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_tx_data,
`ifdef WTA_SPI_HOST_LOOPBACK_EN
    input  logic               i_loopback,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic [FRAME_W-1:0] o_rx_data,
    output logic               o_ss,
    output logic               o_mosi,
    input  logic               i_miso
);

    localparam int BIT_W = $clog2(FRAME_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);

    spi_host_state_t    state_q, state_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               ss_q, ss_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               tick;
    logic               timer_clear;
    logic               sample_bit;

    // Divider restarts on every state entry; it is parked while idle.
    assign timer_clear = (state_d != state_q) || (state_q == IDLE);

    wta_spi_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (timer_clear),
        .o_tick  (tick)
    );

`ifdef WTA_SPI_HOST_LOOPBACK_EN
    logic lb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lb_q <= 1'b0;
        end else if (accept) begin
            lb_q <= i_loopback;
        end
    end

    assign sample_bit = lb_q ? mosi_q : i_miso;
`else
    assign sample_bit = i_miso;
`endif

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        accept    = 1'b0;

        unique case (state_q)
            IDLE:  accept = i_start;
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: begin
                if (tick) begin
                    tx_d      = tx_q << 1;
                    rx_d      = (rx_q << 1) | FRAME_W'(sample_bit);
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == BIT_LAST) state_d = HOLD;
                end
            end
            HOLD:  if (tick) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                accept  = i_start;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d   = SETUP;
            tx_d      = i_tx_data;
            bit_cnt_d = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        ss_d      = ~ss_active(state_d);
        busy_d    = ss_active(state_d) || (state_d == HOLD);
        mosi_d    = ss_active(state_d) & tx_d[FRAME_W-1];
        done_d    = (state_d == DONE);
        rx_data_d = (state_d == DONE) ? rx_d : rx_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            rx_data_q <= '0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            rx_data_q <= rx_data_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_ss      = ss_q;
    assign o_mosi    = mosi_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_rx_data = rx_data_q;

endmodule

// File: tb/tb_wta_spi_host.sv
// Bench for wta_spi_host: an 8-bit/div-2 instance and a default 96-bit/div-4 instance.
module tb_wta_spi_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel96 = 1'b0;
    logic        start = 1'b0;
    logic        miso = 1'b0;
    logic [95:0] tx_drv = '0;
`ifdef WTA_SPI_HOST_LOOPBACK_EN
    logic        lb = 1'b0;
`endif

    logic start8, start96;
    assign start8  = start & ~sel96;
    assign start96 = start & sel96;

    logic        busy8, done8, ss8, mosi8;
    logic [7:0]  rx8;
    logic        busy96, done96, ss96, mosi96;
    logic [95:0] rx96;

    wta_spi_host #(.FRAME_W(8), .CLK_DIV(2)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .i_start   (start8),
        .i_tx_data (tx_drv[7:0]),
`ifdef WTA_SPI_HOST_LOOPBACK_EN
        .i_loopback(lb),
`endif
        .o_busy    (busy8),
        .o_done    (done8),
        .o_rx_data (rx8),
        .o_ss      (ss8),
        .o_mosi    (mosi8),
        .i_miso    (miso)
    );

    wta_spi_host dut96 (
        .clk       (clk),
        .rst       (rst),
        .i_start   (start96),
        .i_tx_data (tx_drv),
`ifdef WTA_SPI_HOST_LOOPBACK_EN
        .i_loopback(lb),
`endif
        .o_busy    (busy96),
        .o_done    (done96),
        .o_rx_data (rx96),
        .o_ss      (ss96),
        .o_mosi    (mosi96),
        .i_miso    (miso)
    );

    logic        ss_o, mosi_o, busy_o, done_o;
    logic [95:0] rx_o;
    assign ss_o   = sel96 ? ss96   : ss8;
    assign mosi_o = sel96 ? mosi96 : mosi8;
    assign busy_o = sel96 ? busy96 : busy8;
    assign done_o = sel96 ? done96 : done8;
    assign rx_o   = sel96 ? rx96   : {88'h0, rx8};

    int n_checks = 0;
    int n_fail   = 0;
    logic [95:0] exp_rx_q[$];

    localparam logic [95:0] RESP96 = 96'hDEADBEEF_01234567_89ABCDEF;

    // Drives n_frames frames (start held high when n_frames > 1) while acting as responder.
    task automatic run_frames(input bit big, input logic [95:0] tx, input logic [95:0] resp,
                              input int n_frames, input bit scramble, input int rst_bit,
                              input bit lb_mode);
        int w, cd, c_rel, n_low, k, frames, low_run, high_run, mosi_err, busy_err, budget;
        logic [95:0] mosi_seq, exp_tx, mask, exp_rx;
        logic exp_bit;
        bit finished, saw_done;
        w    = big ? 96 : 8;
        cd   = big ? 4 : 2;
        mask = big ? {96{1'b1}} : 96'hFF;
        @(negedge clk);
        sel96  = big;
        exp_tx = tx & mask;
        tx_drv = exp_tx;
        start  = 1'b1;
        miso   = 1'b0;
`ifdef WTA_SPI_HOST_LOOPBACK_EN
        lb = lb_mode;
`endif
        exp_rx_q.push_back(lb_mode ? exp_tx : (resp & mask));
        c_rel = 0; n_low = 0; frames = 0; low_run = 0; high_run = 0;
        mosi_err = 0; busy_err = 0; budget = 0; mosi_seq = '0; finished = 0;
        while (!finished) begin
            @(negedge clk);
            c_rel++;
            budget++;
            if (n_frames == 1) start = 1'b0;
`ifdef WTA_SPI_HOST_LOOPBACK_EN
            lb = 1'b0;
`endif
            if (scramble) tx_drv = {$urandom, $urandom, $urandom} & mask;
            if (c_rel == 1) begin
                n_checks++;
                if ({ss_o, busy_o} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL frame_start: ss,busy=%b%b required 01", ss_o, busy_o);
                end
            end
            if (ss_o === 1'b0) begin
                if (high_run > 0 && frames > 0) begin
                    n_checks++;
                    if (high_run != cd + 1) begin
                        n_fail++;
                        $display("FAIL ss_gap: ss high %0d cycles, required %0d", high_run, cd + 1);
                    end
                end
                high_run = 0;
                n_low++;
                low_run++;
                k = (n_low - 1) / cd - 1;
                exp_bit = (k < 0) ? exp_tx[w-1] : ((k < w) ? exp_tx[w-1-k] : 1'bx);
                if (mosi_o !== exp_bit) mosi_err++;
                if (busy_o !== 1'b1) busy_err++;
                if (k >= 0 && k < w && (n_low % cd) == 0) mosi_seq[w-1-k] = mosi_o;
                miso = (k >= 0 && k < w && !lb_mode) ? resp[w-1-k] : 1'b0;
                if (rst_bit >= 0 && k == rst_bit && ((n_low - 1) % cd) == 0) begin
                    rst = 1'b1;
                    @(negedge clk);
                    n_checks++;
                    if ({ss_o, busy_o, done_o, mosi_o} !== 4'b1000 || rx_o !== '0) begin
                        n_fail++;
                        $display("FAIL reset_mid_frame: ss,busy,done,mosi=%b%b%b%b rx=%h required 1000 rx=0",
                                 ss_o, busy_o, done_o, mosi_o, rx_o);
                    end
                    rst = 1'b0;
                    miso = 1'b0;
                    void'(exp_rx_q.pop_back());
                    saw_done = 0;
                    for (int i = 0; i < 40; i++) begin
                        @(negedge clk);
                        if (done_o === 1'b1 || ss_o !== 1'b1) saw_done = 1;
                    end
                    n_checks++;
                    if (saw_done) begin
                        n_fail++;
                        $display("FAIL reset_abandon: activity after reset = 1, required 0");
                    end
                    finished = 1;
                end
            end else begin
                if (low_run > 0) begin
                    n_checks++;
                    if (low_run != (w + 1) * cd) begin
                        n_fail++;
                        $display("FAIL ss_low_len: %0d cycles, required %0d", low_run, (w + 1) * cd);
                    end
                    low_run = 0;
                    n_low = 0;
                    high_run = 0;
                end
                high_run++;
                if (mosi_o !== 1'b0) mosi_err++;
                miso = 1'b0;
            end
            if (!finished && done_o === 1'b1) begin
                frames++;
                n_checks++;
                if (c_rel != (w + 2) * cd + 1) begin
                    n_fail++;
                    $display("FAIL done_latency: %0d cycles, required %0d", c_rel, (w + 2) * cd + 1);
                end
                n_checks++;
                if (busy_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_busy: busy=%b required 0", busy_o);
                end
                n_checks++;
                if (exp_rx_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_data: unexpected done, no frame outstanding");
                end else begin
                    exp_rx = exp_rx_q.pop_front();
                    if ((rx_o & mask) !== exp_rx) begin
                        n_fail++;
                        $display("FAIL rx_data: got %h required %h", rx_o, exp_rx);
                    end
                end
                n_checks++;
                if (mosi_seq !== exp_tx || mosi_err != 0 || busy_err != 0) begin
                    n_fail++;
                    $display("FAIL mosi_seq: got %h (bad cycles %0d, busy errs %0d) required %h",
                             mosi_seq, mosi_err, busy_err, exp_tx);
                end
                mosi_seq = '0; mosi_err = 0; busy_err = 0; c_rel = 0;
                if (frames == n_frames) begin
                    start = 1'b0;
                    finished = 1;
                end else begin
                    exp_rx_q.push_back(resp & mask);
                end
            end
            if (!finished && budget > n_frames * ((w + 2) * cd + 1) + 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout: no done after %0d cycles", budget);
                start = 1'b0;
                exp_rx_q.delete();
                finished = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ss8, mosi8, busy8, done8} !== 4'b1000 || rx8 !== 8'h0) begin
            n_fail++;
            $display("FAIL reset8: ss,mosi,busy,done=%b%b%b%b rx=%h required 1000 rx=0",
                     ss8, mosi8, busy8, done8, rx8);
        end
        n_checks++;
        if ({ss96, mosi96, busy96, done96} !== 4'b1000 || rx96 !== '0) begin
            n_fail++;
            $display("FAIL reset96: ss,mosi,busy,done=%b%b%b%b rx=%h required 1000 rx=0",
                     ss96, mosi96, busy96, done96, rx96);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        run_frames(1'b0, 96'hA5, 96'h3C, 1, 1'b0, -1, 1'b0);
        run_frames(1'b0, 96'h81, 96'hC3, 1, 1'b0, -1, 1'b0);
        run_frames(1'b0, 96'hFF, 96'h00, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_default_params();
        logic [95:0] one;
        one = 96'h1;
        run_frames(1'b1, one << 95, RESP96, 1, 1'b0, -1, 1'b0);
        run_frames(1'b1, one << 47, RESP96, 1, 1'b0, -1, 1'b0);
        run_frames(1'b1, one, ~RESP96, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frames(1'b0, 96'h96, 96'h69, 3, 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic [95:0] one;
        one = 96'h1;
        run_frames(1'b1, one << 60, RESP96, 1, 1'b0, 40, 1'b0);
        run_frames(1'b1, one << 12, RESP96, 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_data_latch();
        run_frames(1'b0, 96'hC3, 96'h7E, 1, 1'b1, -1, 1'b0);
        run_frames(1'b1, {$urandom, $urandom, $urandom}, RESP96, 1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_loopback();
        run_frames(1'b0, 96'h5A, 96'h00, 1, 1'b0, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_default_params();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_latch();
`ifdef WTA_SPI_HOST_LOOPBACK_EN
        test_loopback();
`endif
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wta_spi_host.md
# wta_spi_host

Synchronous SPI frame initiator that drives the `ss`/`mosi` pair and samples `miso` of the WTA chip's SPI responders. Used in the FPGA test harness and on-board controller. It loads a full frame, such as the 96-bit pulse-width word for SPI1 or the 16-bit switch/k word for SPI2. It shifts the frame out MSB-first while capturing the returned count/NN bits full-duplex. One instance serves one SPI port.

## Interface
Parameters:
- `FRAME_W`, 96: bits per frame; must be ≥1.
- `CLK_DIV`, 4: `clk` cycles per bit period; must be ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_start` in 1: start request; sampled only while `o_busy`=0.
- `i_tx_data` in `FRAME_W`: frame to send; latched on the accepted start.
- `o_busy` out 1: transfer in progress.
- `o_done` out 1: one-cycle pulse; `o_rx_data` is valid from this cycle.
- `o_rx_data` out `FRAME_W`: last captured frame; held until the next `o_done`.
- `o_ss` out 1: slave select, active low.
- `o_mosi` out 1: serial data to the responder.
- `i_miso` in 1: serial data from the responder.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → DONE → IDLE.
- IDLE:
  - `o_ss`=1, `o_mosi`=0, `o_busy`=0.
  - `i_start`=1 latches `i_tx_data` into the tx shift register and moves to SETUP.
- SETUP, `CLK_DIV` cycles:
  - `o_ss`=0 and `o_busy`=1.
  - `o_mosi` = `tx[FRAME_W-1]`, giving the responder a setup guard.
- SHIFT, `FRAME_W` bit periods of `CLK_DIV` cycles each:
  - Bit k (k=0 first) presents `tx[FRAME_W-1-k]` on `o_mosi` for the whole period.
  - `i_miso` is sampled on the last cycle of the period (divider count = `CLK_DIV-1`) and shifted into the rx register LSB-side. The first received bit ends as the MSB.
  - The tx register shifts left on that same edge.
- HOLD, `CLK_DIV` cycles: `o_ss`=1, `o_mosi`=0, `o_busy`=1.
- DONE, 1 cycle:
  - `o_done`=1 and `o_busy`=0.
  - `o_rx_data` = rx register.
  - The next state is IDLE, unless `i_start`=1 in this cycle; then the start is accepted and the next state is SETUP (back-to-back frames).
- `i_start` while busy is ignored, not queued.
- `i_tx_data` changes after acceptance have no effect on the current frame.
- Bit-period divider: width `$clog2(CLK_DIV)`. It resets to 0 on every state entry and wraps at `CLK_DIV-1`.
- Bit counter: width `$clog2(FRAME_W+1)`. SHIFT exits when it reaches `FRAME_W`.

## Timing
- Reset values: `o_ss`=1, `o_mosi`=0, `o_busy`=0, `o_done`=0, `o_rx_data`=0, state IDLE, all counters 0.
- `rst` asserted mid-frame: on the next edge `o_ss`=1 and the frame is abandoned. No `o_done` is produced and `o_rx_data` is cleared to 0.
- Start accepted at edge E:
  - `o_busy`=1 and `o_ss`=0 from cycle E+1.
  - `o_done` in cycle E + (`FRAME_W`+2)·`CLK_DIV` + 1.
  - Default parameters: 393 cycles.
- `o_ss` stays low for exactly (`FRAME_W`+1)·`CLK_DIV` cycles.
- `o_mosi` changes only on bit-period boundaries.
- `o_mosi` is stable for ≥`CLK_DIV`-1 cycles before each sample edge, matching the responder's `clk`-domain sampling.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `WTA_SPI_HOST_LOOPBACK_EN` defined:
  - Adds input `i_loopback` (1 bit).
  - When `i_loopback`=1 at the accepted start, the capture path samples the internal `o_mosi` instead of `i_miso` for the whole frame, so `o_rx_data` = the latched `i_tx_data`.
  - `i_loopback` is latched with `i_tx_data`.
- Undefined: no `i_loopback` port; capture always uses `i_miso`.

## Structure
- Shared package `wta_spi_pkg`:
  - State enum `spi_host_state_t` (IDLE, SETUP, SHIFT, HOLD, DONE).
  - Constants `SPI1_FRAME_W`=96 and `SPI2_FRAME_W`=16.
  - The package is also used by the responder-side testbench.
- One sub-module, `wta_spi_bit_timer`:
  - The `CLK_DIV` divider, emitting `o_tick` on the last cycle of each period.
  - `i_clear` resets the count on state entry.
  - The FSM and shift registers stay in the top module.

## Test plan
- Basic frame (`FRAME_W`=8, `CLK_DIV`=2):
  - Stimulus: start with `i_tx_data`=0xA5 and `i_miso` driven from a model returning 0x3C.
  - Expected: `o_mosi` sequence 1,0,1,0,0,1,0,1; `o_done` exactly 21 cycles after the start edge; `o_rx_data`=0x3C; `o_ss` low for 18 cycles.
- Default parameters:
  - Stimulus: 96-bit frame with a walking-1 pattern, against the responder model.
  - Expected: `o_done` at cycle 393 and `o_rx_data` equal to the responder's preloaded 96-bit count word.
- Busy and back-to-back starts:
  - Stimulus: `i_start` held high continuously.
  - Expected: mid-frame starts are ignored; a new frame begins with SETUP on the cycle after each `o_done`; `o_ss` high for exactly `CLK_DIV`+1 cycles between frames.
- Reset mid-frame:
  - Stimulus: assert `rst` during bit 40.
  - Expected: `o_ss`=1, `o_busy`=0, `o_rx_data`=0 on the next edge; no `o_done`; a following start completes normally.
- Data latch:
  - Stimulus: change `i_tx_data` every cycle after start.
  - Expected: the transmitted bits equal the value at the accepted start.
- Loopback (`WTA_SPI_HOST_LOOPBACK_EN` defined, `i_loopback`=1, `i_miso` tied 0):
  - Stimulus: frame 0x5A.
  - Expected: `o_rx_data`=0x5A.
